hwstack: RTL and testbench

Parametrised hardware data stack for the small1 core and HLS-generated datapaths. It keeps top-of-stack (TOS) and next-of-stack (NOS) in registers and spills deeper entries to a synchronous block RAM. TOS and NOS are therefore available every cycle with zero read latency, while the BRAM stays fully registered. It adds push/pop/replace semantics, occupancy count, full/empty status and sticky overflow/underflow flags. An optional random-access peek port can be compiled in.

---
 rtl/stack_pkg.sv | 17 +
 rtl/stack_mem.sv | 31 +++
 rtl/hwstack.sv | 150 +++++++++++++++
 tb/tb_hwstack.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared constants for the hwstack data stack: default geometry, count-width
// derivation and the bit positions of the refused-op error flags.
package stack_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 256;

  // Bit index of each sticky error flag inside the 2-bit error vector.
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UNF_BIT = 1;
  localparam int ERR_W       = 2;

  function automatic int cntw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Spill RAM for hwstack: one write port and one registered read port, plus
// a second registered read port when STACK_PEEK_EN is defined.
module stack_mem #(
  parameter int WIDTH = 32,
  parameter int WORDS = 254,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
`ifdef STACK_PEEK_EN
  ,
  input  logic [AW-1:0]    i_paddr,
  output logic [WIDTH-1:0] o_pdata
`endif
);

  (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [WORDS];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
`ifdef STACK_PEEK_EN
    o_pdata <= r_mem[i_paddr];
`endif
  end

endmodule

// File: rtl/hwstack.sv
// Hardware data stack with TOS/NOS in registers and deeper entries spilled to
// block RAM. Optional random-access peek port under STACK_PEEK_EN.
module hwstack
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNTW  = cntw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] datain,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CNTW-1:0]  count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic [CNTW-1:0]  peek_off,
  output logic [WIDTH-1:0] peek_data
);

  localparam int WORDS = DEPTH - 2;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [WIDTH-1:0] r_tos, r_nos, r_third;
  logic [CNTW-1:0]  r_count;
  logic [ERR_W-1:0] r_err;

  logic             w_empty, w_full;
  logic             w_do_push, w_do_pop, w_do_rep, w_ovf, w_unf;
  logic [CNTW-1:0]  w_next_count;
  logic [ERR_W-1:0] w_err_set;
  logic             w_we;
  logic [AW-1:0]    w_waddr, w_raddr;
  logic [WIDTH-1:0] w_rdata;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNTW'(DEPTH));
  assign w_do_push = push & ~pop & ~w_full;
  assign w_do_pop  = pop & ~push & ~w_empty;
  assign w_do_rep  = push & pop & ~w_empty;
  assign w_ovf     = push & ~pop & w_full;
  assign w_unf     = pop & w_empty;

  always_comb begin
    w_err_set              = '0;
    w_err_set[ERR_OVF_BIT] = w_ovf;
    w_err_set[ERR_UNF_BIT] = w_unf;
  end

  always_comb begin
    w_next_count = r_count;
    if (w_do_push)     w_next_count = r_count + CNTW'(1);
    else if (w_do_pop) w_next_count = r_count - CNTW'(1);
  end

  // The read is addressed from next count so that mem[count-4] is already
  // sitting on the RAM output when the following pop needs it.
  assign w_we    = w_do_push & (r_count >= CNTW'(2));
  assign w_waddr = AW'(r_count - CNTW'(2));
  assign w_raddr = AW'(w_next_count - CNTW'(4));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tos   <= '0;
      r_nos   <= '0;
      r_third <= '0;
      r_count <= '0;
      r_err   <= '0;
    end else begin
      r_count <= w_next_count;
      r_err   <= (r_err & ~{ERR_W{clr_flags}}) | w_err_set;
      if (w_do_push) begin
        r_tos   <= datain;
        r_nos   <= r_tos;
        r_third <= r_nos;
      end else if (w_do_pop) begin
        r_tos   <= r_nos;
        r_nos   <= r_third;
        r_third <= (r_count >= CNTW'(4)) ? w_rdata : '0;
      end else if (w_do_rep) begin
        r_tos <= datain;
      end
    end
  end

`ifdef STACK_PEEK_EN
  logic [AW-1:0]    w_paddr;
  logic [WIDTH-1:0] w_pdata;
  logic [WIDTH-1:0] r_peek_reg;
  logic             r_peek_mem;

  assign w_paddr = AW'(r_count - CNTW'(1) - peek_off);

  stack_mem #(.WIDTH(WIDTH), .WORDS(WORDS), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (r_nos),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata),
    .i_paddr (w_paddr),
    .o_pdata (w_pdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_peek_reg <= '0;
      r_peek_mem <= 1'b0;
    end else begin
      r_peek_mem <= 1'b0;
      r_peek_reg <= '0;
      if (peek_off >= r_count)         r_peek_reg <= '0;
      else if (peek_off == CNTW'(0))   r_peek_reg <= r_tos;
      else if (peek_off == CNTW'(1))   r_peek_reg <= r_nos;
      else                             r_peek_mem <= 1'b1;
    end
  end

  assign peek_data = r_peek_mem ? w_pdata : r_peek_reg;
`else
  logic w_unused_peek;
  assign w_unused_peek = ^peek_off;

  stack_mem #(.WIDTH(WIDTH), .WORDS(WORDS), .AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (r_nos),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign peek_data = '0;
`endif

  assign tos       = r_tos;
  assign nos       = r_nos;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_err[ERR_OVF_BIT];
  assign underflow = r_err[ERR_UNF_BIT];

endmodule

// File: tb/tb_hwstack.sv
// Directed self-checking bench for hwstack (DEPTH=8, WIDTH=32); the peek
// checks follow STACK_PEEK_EN.
module tb_hwstack;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst, push, pop, clr_flags;
  logic [W-1:0]  datain;
  logic [CW-1:0] peek_off;
  logic [W-1:0]  tos, nos, peek_data;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hwstack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .datain(datain),
    .clr_flags(clr_flags), .tos(tos), .nos(nos), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
    .peek_off(peek_off), .peek_data(peek_data)
  );

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 1ns after the capturing edge.
  task automatic step(input logic p, input logic q, input logic [W-1:0] d,
                      input logic c, input logic r);
    @(negedge clk);
    push = p; pop = q; datain = d; clr_flags = c; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [W-1:0] d); step(1, 0, d, 0, 0); endtask
  task automatic do_pop();                        step(0, 1, 0, 0, 0); endtask
  task automatic idle();                          step(0, 0, 0, 0, 0); endtask
  task automatic clr();                           step(0, 0, 0, 1, 0); endtask

  task automatic chk_ts(input string tag, input logic [W-1:0] et,
                        input logic [W-1:0] en, input int ec);
    chk({tag, ".tos"}, tos, et);
    chk({tag, ".nos"}, nos, en);
    chk({tag, ".count"}, W'(count), W'(ec));
  endtask

  initial begin
    push = 0; pop = 0; datain = 0; clr_flags = 0; rst = 1; peek_off = '0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk_ts("reset", 0, 0, 0);
    chk("reset.empty", W'(empty), 1);
    chk("reset.full", W'(full), 0);
    chk("reset.ovf", W'(overflow), 0);
    chk("reset.unf", W'(underflow), 0);

    do_push(32'h11); do_push(32'h22); do_push(32'h33);
    chk_ts("push3", 32'h33, 32'h22, 3);
    do_pop();
    chk_ts("pop1", 32'h22, 32'h11, 2);
    do_pop(); do_pop();
    chk("drain.empty", W'(empty), 1);

    for (int i = 1; i <= D; i++) begin
      do_push(W'(i));
      chk("fill.tos", tos, W'(i));
    end
    chk("fill.full", W'(full), 1);
    do_push(32'h9);
    chk("ovf.flag", W'(overflow), 1);
    chk_ts("ovf", 8, 7, 8);
    for (int i = 0; i < D; i++) begin
      chk("drain8.tos", tos, W'(D - i));
      chk("drain8.nos", nos, (i == D - 1) ? 0 : W'(D - 1 - i));
      do_pop();
    end
    chk_ts("drain8.end", 0, 0, 0);
    chk("drain8.empty", W'(empty), 1);
    chk("ovf.sticky", W'(overflow), 1);
    clr();
    chk("ovf.clr", W'(overflow), 0);

    do_pop();
    chk("unf.flag", W'(underflow), 1);
    chk_ts("unf", 0, 0, 0);
    clr();
    chk("unf.clr", W'(underflow), 0);
    step(0, 1, 0, 1, 0);
    chk("unf.setwins", W'(underflow), 1);
    clr();
    chk("unf.clr2", W'(underflow), 0);
    step(1, 1, 32'h77, 0, 0);
    chk("rep_empty.unf", W'(underflow), 1);
    chk_ts("rep_empty", 0, 0, 0);
    clr();

    do_push(32'hA); do_push(32'hB); do_push(32'hC);
    do_pop();
    chk_ts("byp.pop", 32'hB, 32'hA, 2);
    do_push(32'hD);
    chk_ts("byp.push", 32'hD, 32'hB, 3);
    do_pop();
    chk_ts("byp.pop2", 32'hB, 32'hA, 2);
    do_pop();
    chk_ts("byp.pop3", 32'hA, 0, 1);
    do_pop();

    for (int i = 1; i <= 6; i++) do_push(W'(i));
    do_pop();
    chk_ts("deep.pop", 5, 4, 5);
    do_push(32'h9);
    chk_ts("deep.push", 9, 5, 6);
    do_pop();
    chk_ts("deep.p1", 5, 4, 5);
    do_pop();
    chk_ts("deep.p2", 4, 3, 4);
    do_pop();
    chk_ts("deep.p3", 3, 2, 3);
    do_pop();
    chk_ts("deep.p4", 2, 1, 2);
    step(0, 0, 0, 0, 1);

    do_push(32'h6); do_push(32'h5);
    chk_ts("rep.pre", 5, 6, 2);
    step(1, 1, 32'h7, 0, 0);
    chk_ts("rep", 7, 6, 2);
    do_pop();
    do_push(32'h3); do_push(32'h4);
    do_pop(); do_pop();
    chk_ts("rep.after", 6, 0, 1);
    do_push(32'h8); do_push(32'h9); do_pop();
    do_pop(); do_pop();
    do_push(32'h1); do_pop(); do_pop();
    chk("unf.again", W'(underflow), 1);
    do_push(32'h2); do_push(32'h3);
    step(1, 0, 32'h4, 0, 1);
    chk_ts("rst.mid", 0, 0, 0);
    chk("rst.ovf", W'(overflow), 0);
    chk("rst.unf", W'(underflow), 0);
    chk("rst.empty", W'(empty), 1);

    for (int i = 1; i <= 5; i++) do_push(W'(i));
    peek_off = CW'(0); idle();
`ifdef STACK_PEEK_EN
    chk("peek0", peek_data, 5);
    peek_off = CW'(4); idle();
    chk("peek4", peek_data, 1);
    peek_off = CW'(2); idle();
    chk("peek2", peek_data, 3);
    peek_off = CW'(5); idle();
    chk("peek5", peek_data, 0);
    peek_off = CW'(0); do_push(32'h6);
    chk("peek.pre_op", peek_data, 5);
`else
    chk("peek.off", peek_data, 0);
    peek_off = CW'(4); idle();
    chk("peek.off4", peek_data, 0);
`endif
    chk_ts("peek.stack", tos, nos, count == CW'(6) ? 6 : 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
